// File: rtl/mod7_tracker.sv
// mod7_tracker: decodes a sampled mod-7 up/down counter stream into steps, position, lock and error status
// ports: clk, rst_n (async active-low) | valid_in, value_in[2:0] sample, clr clears pos/err_cnt
//        step_up/step_dn/err one-cycle pulses, dir_out last direction, pos signed net steps,
//        locked high in LOCK, err_cnt saturating error count
module mod7_tracker #(
  parameter int POS_W  = 16,
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       value_in,
  input  logic             clr,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir_out,
  output logic [POS_W-1:0] pos,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
  state_t state, state_n;
  logic [2:0] prev, prev_n, up_v, dn_v;
  logic [GW-1:0] good, good_n;
  logic [POS_W-1:0] pos_n;
  logic su_n, sd_n, err_n, dir_n, ill, hold, is_up, is_dn;
  assign up_v  = (prev == 3'd6) ? 3'd0 : 3'(prev + 3'd1);
  assign dn_v  = (prev == 3'd0) ? 3'd6 : 3'(prev - 3'd1);
  assign ill   = value_in == 3'd7;
  assign hold  = value_in == prev;
  assign is_up = value_in == up_v;
  assign is_dn = value_in == dn_v;
  assign locked = state == LOCK;
  always_comb begin
    state_n = state;
    prev_n  = prev;
    good_n  = good;
    pos_n   = pos;
    dir_n   = dir_out;
    su_n    = 1'b0;
    sd_n    = 1'b0;
    err_n   = 1'b0;
    if (valid_in) begin
      if (ill) begin
        err_n   = 1'b1;
        state_n = IDLE;
      end else if (state == IDLE) begin
        prev_n  = value_in;
        good_n  = '0;
        state_n = ACQ;
      end else if (hold || is_up || is_dn) begin
        su_n   = is_up;
        sd_n   = is_dn;
        dir_n  = is_up ? 1'b1 : is_dn ? 1'b0 : dir_out;
        pos_n  = is_up ? pos + POS_W'(1) : is_dn ? pos - POS_W'(1) : pos;
        prev_n = value_in;
        if (state == ACQ) begin
          good_n  = good + GW'(1);
          state_n = (good_n == GW'(LOCK_N)) ? LOCK : ACQ;
        end
      end else begin
        err_n   = 1'b1;
        prev_n  = value_in;
        good_n  = '0;
        state_n = ACQ;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= '0;
      good    <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
      dir_out <= 1'b0;
      pos     <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_n;
      prev    <= prev_n;
      good    <= good_n;
      step_up <= su_n;
      step_dn <= sd_n;
      err     <= err_n;
      dir_out <= dir_n;
      pos     <= clr ? '0 : pos_n;
      err_cnt <= clr ? '0 : (err_n && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
    end
  end
endmodule

// File: tb/tb_mod7_tracker.sv
// tb_mod7_tracker: directed self-checking bench for mod7_tracker
module tb_mod7_tracker;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, clr = 1'b0;
  logic [2:0] value_in = '0;
  logic step_up, step_dn, dir_out, locked, err;
  logic [15:0] pos;
  logic [7:0] err_cnt;
  logic s4_up, s4_dn, s4_dir, s4_lk, s4_err;
  logic [3:0] pos4;
  logic [7:0] ec4;
  int errors = 0, checks = 0, n;
  mod7_tracker dut (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .value_in(value_in), .clr(clr),
    .step_up(step_up), .step_dn(step_dn), .dir_out(dir_out), .pos(pos), .locked(locked), .err(err), .err_cnt(err_cnt));
  mod7_tracker #(.POS_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .value_in(value_in), .clr(clr),
    .step_up(s4_up), .step_dn(s4_dn), .dir_out(s4_dir), .pos(pos4), .locked(s4_lk), .err(s4_err), .err_cnt(ec4));
  always #5 clk = ~clk;
  task automatic sample(input logic [2:0] v, input logic c);
    @(negedge clk);
    valid_in = 1'b1;
    value_in = v;
    clr = c;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clr = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({step_up, step_dn, err, locked, dir_out, pos, err_cnt} !== 29'd0) begin
      errors++; $display("FAIL reset outputs got=%h exp 0", {step_up, step_dn, err, locked, dir_out, pos, err_cnt});
    end
    do_reset();
  endtask
  task automatic test_up();
    n = 0;
    sample(3'd3, 1'b0);
    checks++; if (step_up !== 1'b0) begin errors++; $display("FAIL idle_first step_up=%b exp 0", step_up); end
    sample(3'd4, 1'b0); n += step_up;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_one locked=%b exp 0", locked); end
    sample(3'd5, 1'b0); n += step_up;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise locked=%b exp 1", locked); end
    sample(3'd6, 1'b0); n += step_up;
    sample(3'd0, 1'b0); n += step_up;
    checks++; if (n != 4) begin errors++; $display("FAIL up_pulses got=%0d exp 4", n); end
    checks++; if (pos !== 16'd4 || dir_out !== 1'b1) begin errors++; $display("FAIL up_pos pos=%0d dir=%b exp 4/1", pos, dir_out); end
  endtask
  task automatic test_dn();
    do_reset();
    n = 0;
    sample(3'd2, 1'b0);
    sample(3'd1, 1'b0); n += step_dn;
    sample(3'd0, 1'b0); n += step_dn;
    sample(3'd6, 1'b0); n += step_dn;
    checks++; if (step_dn !== 1'b1 || dir_out !== 1'b0) begin errors++; $display("FAIL wrap_dn step_dn=%b dir=%b exp 1/0", step_dn, dir_out); end
    sample(3'd5, 1'b0); n += step_dn;
    checks++; if (n != 4) begin errors++; $display("FAIL dn_pulses got=%0d exp 4", n); end
    checks++; if (pos !== 16'hFFFC || locked !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL dn_state pos=%h lk=%b ec=%0d exp fffc/1/0", pos, locked, err_cnt);
    end
  endtask
  task automatic test_jump();
    sample(3'd4, 1'b0); sample(3'd3, 1'b0); sample(3'd2, 1'b0); sample(3'd1, 1'b0);
    sample(3'd4, 1'b0);
    checks++; if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1 || pos !== 16'hFFF8) begin
      errors++; $display("FAIL jump err=%b lk=%b ec=%0d pos=%h exp 1/0/1/fff8", err, locked, err_cnt, pos);
    end
    sample(3'd5, 1'b0);
    checks++; if (step_up !== 1'b1 || err !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL after_jump up=%b err=%b lk=%b exp 1/0/0", step_up, err, locked);
    end
    sample(3'd6, 1'b0);
    checks++; if (locked !== 1'b1 || pos !== 16'hFFFA) begin errors++; $display("FAIL relock lk=%b pos=%h exp 1/fffa", locked, pos); end
  endtask
  task automatic test_illegal();
    sample(3'd7, 1'b0);
    checks++; if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL illegal err=%b lk=%b ec=%0d exp 1/0/2", err, locked, err_cnt);
    end
    sample(3'd2, 1'b0);
    checks++; if ({step_up, step_dn, err} !== 3'b000) begin errors++; $display("FAIL idle_reacq pulses=%b exp 000", {step_up, step_dn, err}); end
    sample(3'd3, 1'b0);
    checks++; if (step_up !== 1'b1 || pos !== 16'hFFFB) begin errors++; $display("FAIL post_idle up=%b pos=%h exp 1/fffb", step_up, pos); end
  endtask
  task automatic test_gap();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if ({step_up, step_dn, err} !== 3'b000) begin errors++; $display("FAIL gap%0d pulses=%b exp 000", i, {step_up, step_dn, err}); end
    end
    sample(3'd4, 1'b0);
    checks++; if (step_up !== 1'b1 || pos !== 16'hFFFC) begin errors++; $display("FAIL gap_step up=%b pos=%h exp 1/fffc", step_up, pos); end
    @(posedge clk);
    #1;
    checks++; if (step_up !== 1'b0) begin errors++; $display("FAIL gap_single up=%b exp 0", step_up); end
  endtask
  task automatic test_back_to_back();
    sample(3'd5, 1'b1);
    checks++; if (step_up !== 1'b1 || pos !== 16'd0 || err_cnt !== 8'd0 || pos4 !== 4'd0) begin
      errors++; $display("FAIL clr_step up=%b pos=%h ec=%0d pos4=%h exp 1/0/0/0", step_up, pos, err_cnt, pos4);
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      sample(3'((6 + i) % 7), 1'b0);
      n += step_up;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_pulses got=%0d exp 8", n); end
    checks++; if (pos4 !== 4'h8 || pos !== 16'd8) begin errors++; $display("FAIL pos_wrap pos4=%h pos=%h exp 8/0008", pos4, pos); end
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 300; i++) sample(3'd7, 1'b0);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd255 || locked !== 1'b0) begin
      errors++; $display("FAIL err_sat err=%b ec=%0d lk=%b exp 1/255/0", err, err_cnt, locked);
    end
  endtask
  task automatic test_async_reset();
    sample(3'd1, 1'b0);
    sample(3'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({step_up, step_dn, err, locked, dir_out, pos, err_cnt} !== 29'd0) begin
      errors++; $display("FAIL async_rst outputs=%h exp 0", {step_up, step_dn, err, locked, dir_out, pos, err_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample(3'd4, 1'b0);
    checks++; if ({step_up, step_dn, err} !== 3'b000) begin errors++; $display("FAIL rst_idle pulses=%b exp 000", {step_up, step_dn, err}); end
    sample(3'd5, 1'b0);
    checks++; if (step_up !== 1'b1 || pos !== 16'd1) begin errors++; $display("FAIL rst_resume up=%b pos=%h exp 1/1", step_up, pos); end
  endtask
  initial begin
    test_reset();
    test_up();
    test_dn();
    test_jump();
    test_illegal();
    test_gap();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
